// File: rtl/preg_freelist_if.sv
// Rename/commit/flush port bundle for the physical-register free list.
// The master is the pipeline side, and the slave is the free-list manager.
interface preg_freelist_if #(
  parameter int unsigned PW = 3
);

  // Rename side: allocation handshake and the granted preg
  logic          alloc_req;
  logic          alloc_ready;
  logic [PW-1:0] alloc_preg;

  // Commit side: retire the oldest speculative allocation and return a preg
  logic          commit_alloc;
  logic          free_valid;
  logic [PW-1:0] free_preg;

  // Pipeline flush: squash all speculative allocations
  logic          flush;

  // Status
  logic [PW:0]   free_count;
  logic          err;

  modport master (
    output alloc_req,
    output commit_alloc,
    output free_valid,
    output free_preg,
    output flush,
    input  alloc_ready,
    input  alloc_preg,
    input  free_count,
    input  err
  );

  modport slave (
    input  alloc_req,
    input  commit_alloc,
    input  free_valid,
    input  free_preg,
    input  flush,
    output alloc_ready,
    output alloc_preg,
    output free_count,
    output err
  );

endinterface

// File: rtl/preg_freelist.sv
// Physical-register free list: a circular FIFO of free preg IDs.
// The head pointer marks the next preg to hand to rename, and the tail pointer
// marks where commit returns pregs. The commit_head pointer trails head. The
// entries from commit_head up to head are speculative allocations, and a
// flush gives all of them back in one cycle.
module preg_freelist #(
  parameter int unsigned NPREG = 8,
  parameter int unsigned PW    = $clog2(NPREG)
) (
  input  logic           clk,
  input  logic           rstn,
  preg_freelist_if.slave fl
);

  // Pointer width: the extra MSB is the wrap bit, so full and empty differ
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] fifo [NPREG];
  logic [CW-1:0] head;
  logic [CW-1:0] commit_head;
  logic [CW-1:0] tail;
  logic          err_q;

  logic [CW-1:0] free_cnt;
  logic [CW-1:0] spec_cnt;
  logic          full;
  logic          alloc_ready_c;
  logic          alloc_fire;
  logic          free_do;
  logic          commit_do;
  logic          err_evt;
  logic [CW-1:0] commit_head_nxt;
  logic [CW-1:0] head_nxt;

  // Occupancy values, taken from the registered pointers (state at the start of the cycle)
  assign free_cnt = tail - head;
  assign spec_cnt = head - commit_head;
  assign full     = (free_cnt == CW'(NPREG));

  // Allocation is zero-cycle. It is blocked during reset and during a flush.
  // A free in the same cycle does not bypass into the allocation.
  assign alloc_ready_c = rstn && !fl.flush && (free_cnt != '0);
  assign alloc_fire    = fl.alloc_req && alloc_ready_c;
  assign free_do       = fl.free_valid && !full;
  assign commit_do     = fl.commit_alloc && (spec_cnt != '0);
  assign err_evt       = (fl.free_valid && full) || (fl.commit_alloc && (spec_cnt == '0));

  assign fl.alloc_ready = alloc_ready_c;
  assign fl.alloc_preg  = fifo[head[PW-1:0]];
  assign fl.free_count  = free_cnt;
  assign fl.err         = err_q;

  // Next pointer values. The commit applies first, and a flush then rewinds head to the new commit_head.
  always_comb begin
    commit_head_nxt = commit_head;
    head_nxt        = head;
    if (commit_do) begin
      commit_head_nxt = commit_head + CW'(1);
    end
    if (fl.flush) begin
      head_nxt = commit_head_nxt;
    end else if (alloc_fire) begin
      head_nxt = head + CW'(1);
    end
  end

  // Pointer and sticky-error registers. Reset leaves every preg free.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      head        <= '0;
      commit_head <= '0;
      tail        <= CW'(NPREG);
      err_q       <= 1'b0;
    end else begin
      head        <= head_nxt;
      commit_head <= commit_head_nxt;
      if (free_do) begin
        tail <= tail + CW'(1);
      end
      if (err_evt) begin
        err_q <= 1'b1;
      end
    end
  end

  // ID storage. Reset loads the identity map, and a free writes at the tail.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NPREG; i++) begin
        fifo[i] <= PW'(i);
      end
    end else if (free_do) begin
      fifo[tail[PW-1:0]] <= fl.free_preg;
    end
  end

endmodule

// File: tb/tb_preg_freelist.sv
// Bench for preg_freelist. It uses directed scenarios followed by legal
// random traffic. All traffic is checked against a queue-based model of the
// free list, the speculative list and the committed (architectural) pool.
module tb_preg_freelist;

  localparam int unsigned NPREG = 8;
  localparam int unsigned PW    = 3;

  logic clk;
  logic rstn;

  preg_freelist_if #(.PW(PW)) fl_if ();

  preg_freelist #(.NPREG(NPREG), .PW(PW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .fl   (fl_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: free pregs in grant order, speculative pregs oldest first, and retired pregs
  logic [PW-1:0] free_q [$];
  logic [PW-1:0] spec_q [$];
  logic [PW-1:0] arch_q [$];
  logic          err_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    fl_if.alloc_req    = 1'b0;
    fl_if.commit_alloc = 1'b0;
    fl_if.free_valid   = 1'b0;
    fl_if.free_preg    = '0;
    fl_if.flush        = 1'b0;
  endtask

  task automatic model_reset();
    free_q.delete();
    spec_q.delete();
    arch_q.delete();
    for (int i = 0; i < int'(NPREG); i++) free_q.push_back(PW'(i));
    err_m = 1'b0;
  endtask

  // Each call runs one clock cycle. The bench drives the inputs, checks the
  // outputs at the negedge and advances the model. It then returns just after
  // the posedge with idle inputs.
  task automatic step(input logic req, input logic cmt, input logic fv,
                      input logic [PW-1:0] fp, input logic fl);
    logic          exp_ready;
    logic          was_full;
    logic [PW-1:0] t;
    fl_if.alloc_req    = req;
    fl_if.commit_alloc = cmt;
    fl_if.free_valid   = fv;
    fl_if.free_preg    = fp;
    fl_if.flush        = fl;
    @(negedge clk);
    exp_ready = !fl && (free_q.size() != 0);
    chk("alloc_ready", 32'(fl_if.alloc_ready), 32'(exp_ready));
    if (exp_ready) chk("alloc_preg", 32'(fl_if.alloc_preg), 32'(free_q[0]));
    chk("free_count", 32'(fl_if.free_count), 32'(free_q.size()));
    chk("err", 32'(fl_if.err), 32'(err_m));
    was_full = (free_q.size() == int'(NPREG));
    if (fv && was_full) err_m = 1'b1;
    if (cmt) begin
      if (spec_q.size() == 0) err_m = 1'b1;
      else begin
        t = spec_q.pop_front();
        arch_q.push_back(t);
      end
    end
    if (fl) begin
      while (spec_q.size() > 0) begin
        t = spec_q.pop_back();
        free_q.push_front(t);
      end
    end else if (req && exp_ready) begin
      t = free_q.pop_front();
      spec_q.push_back(t);
    end
    if (fv && !was_full) free_q.push_back(fp);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  // Observe the settled outputs with idle inputs, just after a clock edge
  task automatic peek(input string tag, input int cnt, input logic rdy,
                      input logic [PW-1:0] preg, input logic e);
    #1;
    chk({tag, "_count"}, 32'(fl_if.free_count), 32'(cnt));
    chk({tag, "_ready"}, 32'(fl_if.alloc_ready), 32'(rdy));
    if (rdy) chk({tag, "_preg"}, 32'(fl_if.alloc_preg), 32'(preg));
    chk({tag, "_err"}, 32'(fl_if.err), 32'(e));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    fl_if.alloc_req = 1'b1;
    #1;
    chk("rst_ready", 32'(fl_if.alloc_ready), 32'd0);
    fl_if.alloc_req = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
  endtask

  initial begin
    logic          r, c, f, fl;
    logic [PW-1:0] p;
    int            idx;
    rstn = 1'b0;
    idle_inputs();
    model_reset();

    // Reset state, then drain all eight pregs
    do_reset();
    peek("after_reset", int'(NPREG), 1'b1, '0, 1'b0);
    for (int i = 0; i < int'(NPREG); i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    peek("drained", 0, 1'b0, '0, 1'b0);

    // A free from empty is not allocatable in the same cycle, only in the next one
    step(1'b1, 1'b0, 1'b1, PW'(5), 1'b0);
    peek("free_from_empty", 1, 1'b1, PW'(5), 1'b0);

    // Allocate 3, commit 1, then flush. The two uncommitted pregs come back.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    peek("flush_restore", 7, 1'b1, PW'(1), 1'b0);

    // Steady state at two free entries, with one alloc and one free per cycle through several wraps
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, PW'($urandom_range(0, NPREG - 1)), 1'b0);
    peek("steady", 2, 1'b1, free_q[0], 1'b0);

    // Overfree while full sets err and is dropped
    do_reset();
    step(1'b0, 1'b0, 1'b1, PW'(2), 1'b0);
    peek("overfree", int'(NPREG), 1'b1, '0, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);

    // A commit with nothing speculative sets err
    do_reset();
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    peek("bad_commit", int'(NPREG), 1'b1, '0, 1'b1);

    // Flush, commit and free in the same cycle after 4 allocs and 1 prior commit
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b1, PW'(3), 1'b1);
    peek("flush_combo", 7, 1'b1, PW'(2), 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    peek("flush_combo_drained", 0, 1'b0, '0, 1'b0);

    // Legal random traffic: only retired pregs are freed, so nothing is lost or duplicated
    do_reset();
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 9) < 7);
      c  = (spec_q.size() > 0) && ($urandom_range(0, 1) == 1);
      fl = ($urandom_range(0, 24) == 0);
      f  = 1'b0;
      p  = '0;
      if (arch_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, arch_q.size() - 1);
        p   = arch_q[idx];
        arch_q.delete(idx);
        f   = 1'b1;
      end
      step(r, c, f, p, fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
